// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the PISO serializer
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// rtl/piso_hold_reg.sv - one-entry data+valid holding register with load/drain
module piso_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with one-word holding register
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             accept;
  logic             at_last;
  logic             end_word;
  logic             hold_load;
  logic             hold_drain;

  assign load_ready = !hold_valid && !reset;
  assign accept     = load_valid && load_ready;
  assign at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign end_word   = at_last && shift_en;

  // A word arriving mid-frame parks in the holding register; at end of
  // word the held word takes priority over a same-edge accept.
  assign hold_load  = accept && (state_q == SHIFT) && !end_word;
  assign hold_drain = end_word && hold_valid;

  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_data(load_data),
    .drain    (hold_drain),
    .data     (hold_data),
    .valid    (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (at_last) begin
            cnt_d = '0;
            if (hold_valid) begin
              sreg_d = hold_data;
            end else if (accept) begin
              sreg_d = load_data;
            end else begin
              state_d = IDLE;
              sreg_d  = sreg_shifted;
            end
          end else begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sout_valid = (state_q == SHIFT);
    sout       = 1'b0;
    if (state_q == SHIFT) begin
      sout = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
    last = at_last;
    busy = (state_q == SHIFT) || hold_valid;
  end

endmodule
